sc_core_oz_lsu: RTL and testbench

Load/store unit sitting directly downstream of the register file in the sc_core_oz datapath. It consumes the ALU-computed address and RegRdData2 (store data), runs a req/grant/response handshake to data memory, and returns the aligned, sign- or zero-extended load result that feeds the writeback mux (WrBackData). While a memory access is outstanding it stalls the otherwise single-cycle core.

---
 rtl/sc_core_oz_lsu.sv | 183 ++++++++++++++++++
 tb/tb_sc_core_oz_lsu.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_core_oz_lsu.sv
// sc_core_oz_lsu: load/store unit between the register file and data memory.
// Runs the req/grant/response handshake, stalls the core while busy and extends load data.
module sc_core_oz_lsu #(
  parameter int unsigned TIMEOUT_CYCLES  = 16,
  parameter logic [31:0] RESET_LOAD_DATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CtrlLoad,
  input  logic        CtrlStore,
  input  logic [2:0]  Funct3,
  input  logic [31:0] AluOut,
  input  logic [31:0] RegRdData2,
  output logic        LsuStall,
  output logic [31:0] LoadData,
  output logic        MisalignedExc,
  output logic        BusErr,
  output logic        DmemReq,
  output logic        DmemWr,
  output logic [31:0] DmemAddr,
  output logic [3:0]  DmemByteEn,
  output logic [31:0] DmemWrData,
  input  logic        DmemGnt,
  input  logic        DmemRspValid,
  input  logic [31:0] DmemRdData
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  logic            op;
  logic            at_limit;
  logic            legal_c;
  logic [3:0]      be_c;
  logic [31:0]     wd_c;
  logic [7:0]      rd_byte_c;
  logic [15:0]     rd_half_c;
  logic [31:0]     ext_c;

  assign op       = CtrlLoad | CtrlStore;
  assign at_limit = (cnt == CntLast);

  // The core must not see a stall while the unit itself is held in reset.
  assign LsuStall = op & (state != S_DONE) & ~rst;

  // Access legality, byte lanes and lane-replicated store data for the incoming op.
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b0000;
    wd_c    = 32'h0;
    case (Funct3)
      F3_LB, F3_LBU: begin
        legal_c = 1'b1;
        be_c    = 4'b0001 << AluOut[1:0];
        wd_c    = {4{RegRdData2[7:0]}};
      end
      F3_LH, F3_LHU: begin
        legal_c = ~AluOut[0];
        be_c    = 4'b0011 << AluOut[1:0];
        wd_c    = {2{RegRdData2[15:0]}};
      end
      F3_LW: begin
        legal_c = (AluOut[1:0] == 2'b00);
        be_c    = 4'b1111;
        wd_c    = RegRdData2;
      end
      default: begin
        legal_c = 1'b0;
      end
    endcase
  end

  // Extract the addressed lane of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte_c = DmemRdData[7:0];
      2'd1:    rd_byte_c = DmemRdData[15:8];
      2'd2:    rd_byte_c = DmemRdData[23:16];
      default: rd_byte_c = DmemRdData[31:24];
    endcase
    rd_half_c = off_q[1] ? DmemRdData[31:16] : DmemRdData[15:0];
    case (f3_q)
      F3_LB:   ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
      F3_LBU:  ext_c = {24'h0, rd_byte_c};
      F3_LH:   ext_c = {{16{rd_half_c[15]}}, rd_half_c};
      F3_LHU:  ext_c = {16'h0, rd_half_c};
      default: ext_c = DmemRdData;
    endcase
  end

  // Access sequencer: captures the request, tracks the handshake and aborts on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      DmemReq       <= 1'b0;
      DmemWr        <= 1'b0;
      DmemAddr      <= 32'h0;
      DmemByteEn    <= 4'b0000;
      DmemWrData    <= 32'h0;
      LoadData      <= RESET_LOAD_DATA;
      MisalignedExc <= 1'b0;
      BusErr        <= 1'b0;
    end else begin
      MisalignedExc <= 1'b0;
      BusErr        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op && legal_c) begin
            state      <= S_REQ;
            cnt        <= '0;
            DmemReq    <= 1'b1;
            DmemWr     <= CtrlStore;
            DmemAddr   <= {AluOut[31:2], 2'b00};
            DmemByteEn <= be_c;
            DmemWrData <= wd_c;
            f3_q       <= Funct3;
            off_q      <= AluOut[1:0];
          end else if (op) begin
            state         <= S_DONE;
            MisalignedExc <= 1'b1;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (DmemGnt && (DmemWr || DmemRspValid)) begin
            state   <= S_DONE;
            DmemReq <= 1'b0;
            if (!DmemWr) begin
              LoadData <= ext_c;
            end
          end else if (at_limit) begin
            state    <= S_DONE;
            DmemReq  <= 1'b0;
            BusErr   <= 1'b1;
            LoadData <= RESET_LOAD_DATA;
          end else if (DmemGnt) begin
            state   <= S_WAIT;
            DmemReq <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (DmemRspValid) begin
            state    <= S_DONE;
            LoadData <= ext_c;
          end else if (at_limit) begin
            state    <= S_DONE;
            BusErr   <= 1'b1;
            LoadData <= RESET_LOAD_DATA;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_core_oz_lsu.sv
// Scoreboard bench for sc_core_oz_lsu: stimulus queues expected requests/completions,
// a monitor pops and compares them whenever the DUT issues a request or completes.
`timescale 1ns/1ps
module tb_sc_core_oz_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        CtrlLoad, CtrlStore;
  logic [2:0]  Funct3;
  logic [31:0] AluOut, RegRdData2;
  logic        LsuStall;
  logic [31:0] LoadData;
  logic        MisalignedExc, BusErr;
  logic        DmemReq, DmemWr;
  logic [31:0] DmemAddr;
  logic [3:0]  DmemByteEn;
  logic [31:0] DmemWrData;
  logic        DmemGnt, DmemRspValid;
  logic [31:0] DmemRdData;

  sc_core_oz_lsu #(.TIMEOUT_CYCLES(16), .RESET_LOAD_DATA(32'h0)) dut (
    .clk(clk), .rst(rst),
    .CtrlLoad(CtrlLoad), .CtrlStore(CtrlStore), .Funct3(Funct3),
    .AluOut(AluOut), .RegRdData2(RegRdData2),
    .LsuStall(LsuStall), .LoadData(LoadData),
    .MisalignedExc(MisalignedExc), .BusErr(BusErr),
    .DmemReq(DmemReq), .DmemWr(DmemWr), .DmemAddr(DmemAddr),
    .DmemByteEn(DmemByteEn), .DmemWrData(DmemWrData),
    .DmemGnt(DmemGnt), .DmemRspValid(DmemRspValid), .DmemRdData(DmemRdData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic        exc;
    logic        berr;
    logic [31:0] ld;
    int          stall;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle, after stimulus has settled.
  initial begin : monitor
    int   stall_n;
    logic prev_req;
    req_t er;
    rsp_t ep;
    stall_n  = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_n  = 0;
        prev_req = 1'b0;
      end else begin
        if (DmemReq && !prev_req) begin
          chk("req_expected", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            er = req_q.pop_front();
            chk("req_wr", 32'(DmemWr), 32'(er.wr));
            chk("req_addr", DmemAddr, er.addr);
            chk("req_byteen", 32'(DmemByteEn), 32'(er.be));
            if (er.wr) chk("req_wrdata", DmemWrData, er.wd);
          end
        end
        prev_req = DmemReq;
        if ((CtrlLoad || CtrlStore) && !LsuStall) begin
          chk("done_expected", 32'(rsp_q.size() != 0), 32'd1);
          if (rsp_q.size() != 0) begin
            ep = rsp_q.pop_front();
            chk("done_misaligned", 32'(MisalignedExc), 32'(ep.exc));
            chk("done_buserr", 32'(BusErr), 32'(ep.berr));
            chk("done_loaddata", LoadData, ep.ld);
            chk("done_stall_cycles", 32'(stall_n), 32'(ep.stall));
            chk("done_req_low", 32'(DmemReq), 32'd0);
          end
          stall_n = 0;
        end else begin
          if (CtrlLoad || CtrlStore) stall_n++;
          chk("no_stray_pulse", {30'h0, MisalignedExc, BusErr}, 32'h0);
        end
      end
    end
  end

  // Drives one op and a memory responder until the DUT drops LsuStall (-1 = never).
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gnt_dly, input int rsp_dly, input logic [31:0] rdata);
    int   reqs;
    int   gcnt;
    logic gnted;
    logic done;
    reqs  = 0;
    gcnt  = 0;
    gnted = 1'b0;
    done  = 1'b0;
    @(negedge clk);
    CtrlLoad = ld; CtrlStore = st; Funct3 = f3; AluOut = addr; RegRdData2 = wd;
    DmemRdData = rdata; DmemGnt = 1'b0; DmemRspValid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!LsuStall) begin
        done = 1'b1;
        break;
      end
      DmemGnt = DmemReq && !gnted && (reqs == gnt_dly);
      if (DmemReq) reqs++;
      if (DmemGnt) begin
        gnted = 1'b1;
        gcnt  = 0;
      end
      DmemRspValid = gnted && (gcnt == rsp_dly);
      if (gnted) gcnt++;
      @(negedge clk);
    end
    DmemGnt = 1'b0;
    DmemRspValid = 1'b0;
    chk("op_completes_in_budget", 32'(done), 32'd1);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] waddr,
                         input logic [3:0] be, input logic [31:0] rdata,
                         input int gnt_dly, input int rsp_dly, input logic [31:0] res, input int stall);
    rsp_t r;
    req_q.push_back('{wr: 1'b0, addr: waddr, be: be, wd: 32'h0});
    r.exc = 1'b0; r.berr = 1'b0; r.ld = res; r.stall = stall;
    rsp_q.push_back(r);
    exp_ld = res;
    run_op(1'b1, 1'b0, f3, addr, 32'hA5A5A5A5, gnt_dly, rsp_dly, rdata);
  endtask

  task automatic do_store(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] waddr, input logic [3:0] be,
                          input logic [31:0] lane_wd, input int gnt_dly, input int stall);
    rsp_t r;
    req_q.push_back('{wr: 1'b1, addr: waddr, be: be, wd: lane_wd});
    r.exc = 1'b0; r.berr = 1'b0; r.ld = exp_ld; r.stall = stall;
    rsp_q.push_back(r);
    run_op(ld, 1'b1, f3, addr, wd, gnt_dly, -1, 32'h0);
  endtask

  task automatic do_bad(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr);
    rsp_t r;
    r.exc = 1'b1; r.berr = 1'b0; r.ld = exp_ld; r.stall = 1;
    rsp_q.push_back(r);
    run_op(ld, st, f3, addr, 32'h5A5A5A5A, 0, 0, 32'hFFFFFFFF);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      CtrlLoad = 1'b0; CtrlStore = 1'b0; DmemGnt = 1'b0; DmemRspValid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    rsp_t r;
    rst = 1'b1;
    CtrlLoad = 1'b0; CtrlStore = 1'b0; Funct3 = 3'b000; AluOut = 32'h0; RegRdData2 = 32'h0;
    DmemGnt = 1'b0; DmemRspValid = 1'b0; DmemRdData = 32'h0;
    exp_ld = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", 32'(DmemReq), 32'd0);
    chk("reset_loaddata", LoadData, 32'h0);
    chk("reset_byteen", 32'(DmemByteEn), 32'h0);
    chk("reset_addr", DmemAddr, 32'h0);
    chk("reset_pulses", {30'h0, MisalignedExc, BusErr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Loads: f3, addr, word addr, byte enables, read data, gnt delay, rsp delay, result, stall
    do_load(3'b010, 32'h100, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 3);
    do_load(3'b000, 32'h103, 32'h100, 4'b1000, 32'h80FF0102, 0, 0, 32'hFFFFFF80, 2);
    do_load(3'b100, 32'h103, 32'h100, 4'b1000, 32'h80FF0102, 1, 2, 32'h00000080, 5);
    do_load(3'b001, 32'h102, 32'h100, 4'b1100, 32'h80FF0102, 0, 1, 32'hFFFF80FF, 3);
    do_load(3'b101, 32'h102, 32'h100, 4'b1100, 32'h80FF0102, 0, 0, 32'h000080FF, 2);
    do_load(3'b001, 32'h100, 32'h100, 4'b0011, 32'h80FF8102, 0, 0, 32'hFFFF8102, 2);
    do_load(3'b000, 32'h101, 32'h100, 4'b0010, 32'h80FF0102, 0, 0, 32'h00000001, 2);

    // Stores: load flag, f3, addr, data, word addr, byte enables, lane data, gnt delay, stall
    do_store(1'b0, 3'b000, 32'h201, 32'h12345678, 32'h200, 4'b0010, 32'h78787878, 0, 2);
    do_store(1'b0, 3'b001, 32'h202, 32'h12345678, 32'h200, 4'b1100, 32'h56785678, 2, 4);
    do_store(1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D, 15, 17);
    do_store(1'b1, 3'b000, 32'h202, 32'h000000AB, 32'h200, 4'b0100, 32'hABABABAB, 0, 2);

    // Misaligned and illegal-size accesses
    do_bad(1'b1, 1'b0, 3'b010, 32'h102);
    do_bad(1'b0, 1'b1, 3'b001, 32'h203);
    do_bad(1'b1, 1'b0, 3'b011, 32'h100);
    do_bad(1'b1, 1'b0, 3'b101, 32'h101);
    do_bad(1'b1, 1'b0, 3'b110, 32'h100);

    // Timeout: grant never arrives
    req_q.push_back('{wr: 1'b0, addr: 32'h400, be: 4'b1111, wd: 32'h0});
    r.exc = 1'b0; r.berr = 1'b1; r.ld = 32'h0; r.stall = 17;
    rsp_q.push_back(r);
    exp_ld = 32'h0;
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, -1, 32'h55555555);
    @(negedge clk);
    CtrlLoad = 1'b0; CtrlStore = 1'b0;
    DmemRspValid = 1'b1; DmemRdData = 32'h11111111;
    @(negedge clk);
    DmemRspValid = 1'b0;
    #1;
    chk("late_rsp_ignored", LoadData, 32'h0);

    do_load(3'b010, 32'h104, 32'h104, 4'b1111, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 2);

    // Reset while waiting for read data
    req_q.push_back('{wr: 1'b0, addr: 32'h500, be: 4'b1111, wd: 32'h0});
    @(negedge clk);
    CtrlLoad = 1'b1; CtrlStore = 1'b0; Funct3 = 3'b010; AluOut = 32'h500;
    @(negedge clk);
    DmemGnt = 1'b1;
    @(negedge clk);
    DmemGnt = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_req", 32'(DmemReq), 32'd0);
    chk("rst_async_stall", 32'(LsuStall), 32'd0);
    chk("rst_async_loaddata", LoadData, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    CtrlLoad = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    do_load(3'b010, 32'h600, 32'h600, 4'b1111, 32'h13579BDF, 1, 1, 32'h13579BDF, 4);

    idle(4);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("done_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
